// File: rtl/dma_desc_dispatch.sv
// N-channel descriptor dispatcher: per-channel queues, round-robin issue with outstanding credit
// limits, completion-to-response path, per-channel abort. DMA_DISP_PRIO_EN adds the i_prio mask.
`timescale 1ns/1ps
module dma_desc_dispatch #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int QDEPTH    = 4,
  parameter int MAX_OUT   = 2,
  parameter int PAYLOAD_W = 48
) (
  input  logic                 aclk,
  input  logic                 anreset,
  input  logic                 aenable,
  input  logic [NUM_CH-1:0]    i_abort,
`ifdef DMA_DISP_PRIO_EN
  input  logic [NUM_CH-1:0]    i_prio,
`endif
  input  logic                 i_desc_valid,
  output logic                 o_desc_ready,
  input  logic [CH_W-1:0]      i_desc_ch_sel,
  input  logic [7:0]           i_desc_id,
  input  logic [PAYLOAD_W-1:0] i_desc_payload,
  output logic                 o_issue_valid,
  input  logic                 i_issue_ready,
  output logic [CH_W-1:0]      o_issue_ch,
  output logic [7:0]           o_issue_id,
  output logic [PAYLOAD_W-1:0] o_issue_payload,
  input  logic                 i_cmpl_valid,
  output logic                 o_cmpl_ready,
  input  logic [CH_W-1:0]      i_cmpl_ch,
  input  logic [7:0]           i_cmpl_id,
  output logic                 o_resp_wr,
  output logic [7:0]           o_resp_desc_id,
  output logic [CH_W-1:0]      o_resp_ch_sel,
  input  logic                 i_resp_wready,
  output logic                 o_cmpl_err
);
  localparam int AW = $clog2(QDEPTH);
  localparam int DW = 8 + PAYLOAD_W;
  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  logic [DW-1:0]        r_mem [NUM_CH][QDEPTH];
  logic [AW:0]          r_wptr [NUM_CH];
  logic [AW:0]          r_rptr [NUM_CH];
  logic [3:0]           r_out [NUM_CH];
  logic [CH_W-1:0]      r_rr;
  logic                 r_issue_valid;
  logic [CH_W-1:0]      r_issue_ch;
  logic [7:0]           r_issue_id;
  logic [PAYLOAD_W-1:0] r_issue_payload;
  logic                 r_resp_wr;
  logic [7:0]           r_resp_id;
  logic [CH_W-1:0]      r_resp_ch;
  logic                 r_cmpl_err;

  logic [NUM_CH-1:0] w_hit, w_empty, w_full, w_elig, w_hi, w_inc, w_dec;
  logic              w_desc_blk, w_sel_ok, w_push, w_any, w_load, w_cmpl_fire, w_cmpl_bad;
  logic [CH_W-1:0]   w_sel;
  logic [DW-1:0]     w_rd;

  // First set bit of mask strictly after ptr, wrapping; the reverse scan lets the nearest win.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                              input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] idx;
    int j;
    sel = ptr;
    for (int k = NUM_CH; k >= 1; k--) begin
      j   = (int'(ptr) + k) % NUM_CH;
      idx = CH_W'(j);
      sel = mask[idx] ? idx : sel;
    end
    return sel;
  endfunction

  // Per-channel queue status, eligibility and accept blocking.
  always_comb begin
    w_desc_blk = 1'b0;
    w_sel_ok   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i]   = (i_desc_ch_sel == CH_W'(i));
      w_empty[i] = (r_wptr[i] == r_rptr[i]);
      w_full[i]  = (r_wptr[i][AW] != r_rptr[i][AW]) && (r_wptr[i][AW-1:0] == r_rptr[i][AW-1:0]);
      w_elig[i]  = !w_empty[i] && (r_out[i] < MAX_OUT_C) && !i_abort[i];
      w_desc_blk = w_desc_blk | (w_hit[i] & (w_full[i] | i_abort[i]));
      w_sel_ok   = w_sel_ok | w_hit[i];
    end
  end

  // Arbitration: high-priority eligible channels first, both tiers share r_rr.
  always_comb begin
`ifdef DMA_DISP_PRIO_EN
    w_hi = w_elig & i_prio;
`else
    w_hi = '0;
`endif
    w_any = |w_elig;
    w_sel = (|w_hi) ? rr_pick(w_hi, r_rr) : rr_pick(w_elig, r_rr);
  end

  assign o_desc_ready = aenable & !w_desc_blk;
  assign o_cmpl_ready = aenable & (!r_resp_wr | i_resp_wready);
  assign w_push       = i_desc_valid & o_desc_ready & w_sel_ok;
  assign w_load       = aenable & (!r_issue_valid | i_issue_ready) & w_any;
  assign w_cmpl_fire  = i_cmpl_valid & o_cmpl_ready;
  assign w_cmpl_bad   = w_cmpl_fire & ~|w_dec;
  assign w_rd         = r_mem[w_sel][r_rptr[w_sel][AW-1:0]];

  // Credit deltas; a completion against zero outstanding leaves the counter alone.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_inc[i] = w_load & (w_sel == CH_W'(i));
      w_dec[i] = w_cmpl_fire & (i_cmpl_ch == CH_W'(i)) & (r_out[i] != 4'd0);
    end
  end

  // Queue storage.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push && w_hit[i]) begin
        r_mem[i][r_wptr[i][AW-1:0]] <= {i_desc_id, i_desc_payload};
      end
    end
  end

  // Queue pointers and outstanding counters; abort flushes by snapping rptr to wptr.
  always_ff @(posedge aclk or negedge anreset) begin
    if (!anreset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_out[i]  <= 4'd0;
      end
    end else if (aenable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_abort[i]) begin
          r_rptr[i] <= r_wptr[i];
        end else if (w_inc[i]) begin
          r_rptr[i] <= r_rptr[i] + 1'b1;
        end
        if (w_push && w_hit[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
        r_out[i] <= r_out[i] + {3'b000, w_inc[i]} - {3'b000, w_dec[i]};
      end
    end
  end

  // Issue register, response register and sticky completion error.
  always_ff @(posedge aclk or negedge anreset) begin
    if (!anreset) begin
      r_rr            <= CH_W'(NUM_CH - 1);
      r_issue_valid   <= 1'b0;
      r_issue_ch      <= '0;
      r_issue_id      <= 8'd0;
      r_issue_payload <= '0;
      r_resp_wr       <= 1'b0;
      r_resp_id       <= 8'd0;
      r_resp_ch       <= '0;
      r_cmpl_err      <= 1'b0;
    end else if (aenable) begin
      if (w_load) begin
        r_issue_valid                 <= 1'b1;
        r_issue_ch                    <= w_sel;
        {r_issue_id, r_issue_payload} <= w_rd;
        r_rr                          <= w_sel;
      end else if (i_issue_ready) begin
        r_issue_valid <= 1'b0;
      end
      if (w_cmpl_fire) begin
        r_resp_wr <= 1'b1;
        r_resp_id <= i_cmpl_id;
        r_resp_ch <= i_cmpl_ch;
      end else if (i_resp_wready) begin
        r_resp_wr <= 1'b0;
      end
      if (w_cmpl_bad) begin
        r_cmpl_err <= 1'b1;
      end
    end
  end

  assign o_issue_valid   = r_issue_valid;
  assign o_issue_ch      = r_issue_ch;
  assign o_issue_id      = r_issue_id;
  assign o_issue_payload = r_issue_payload;
  assign o_resp_wr       = r_resp_wr;
  assign o_resp_desc_id  = r_resp_id;
  assign o_resp_ch_sel   = r_resp_ch;
  assign o_cmpl_err      = r_cmpl_err;

endmodule

// File: tb/tb_dma_desc_dispatch.sv
// Bench for dma_desc_dispatch: directed scenarios plus randomized traffic against a queue-based
// reference model. Define DMA_DISP_PRIO_EN for both files to cover the priority feature.
`timescale 1ns/1ps
module tb_dma_desc_dispatch;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int QDEPTH  = 4;
  localparam int MAX_OUT = 2;
  localparam int PW      = 48;

  logic              aclk = 1'b0;
  logic              anreset, aenable;
  logic [NUM_CH-1:0] i_abort;
  logic [NUM_CH-1:0] i_prio;
  logic              i_desc_valid, o_desc_ready;
  logic [CH_W-1:0]   i_desc_ch_sel;
  logic [7:0]        i_desc_id;
  logic [PW-1:0]     i_desc_payload;
  logic              o_issue_valid, i_issue_ready;
  logic [CH_W-1:0]   o_issue_ch;
  logic [7:0]        o_issue_id;
  logic [PW-1:0]     o_issue_payload;
  logic              i_cmpl_valid, o_cmpl_ready;
  logic [CH_W-1:0]   i_cmpl_ch;
  logic [7:0]        i_cmpl_id;
  logic              o_resp_wr;
  logic [7:0]        o_resp_desc_id;
  logic [CH_W-1:0]   o_resp_ch_sel;
  logic              i_resp_wready, o_cmpl_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  logic [55:0] mq [NUM_CH][$];
  int          m_out [NUM_CH];
  int          m_rr;
  bit          m_iv, m_rv, m_err;
  int          m_ich, m_rch;
  logic [7:0]  m_iid, m_rid;
  logic [PW-1:0] m_ipay;
  logic [NUM_CH-1:0] prio_v;
  int hs_ch[$];
  int hs_id[$];
  int hs_cyc[$];

  always #5 aclk = ~aclk;

  dma_desc_dispatch #(.NUM_CH(NUM_CH), .CH_W(CH_W), .QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT),
                      .PAYLOAD_W(PW)) dut (
    .aclk(aclk), .anreset(anreset), .aenable(aenable), .i_abort(i_abort),
`ifdef DMA_DISP_PRIO_EN
    .i_prio(i_prio),
`endif
    .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready), .i_desc_ch_sel(i_desc_ch_sel),
    .i_desc_id(i_desc_id), .i_desc_payload(i_desc_payload),
    .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready), .o_issue_ch(o_issue_ch),
    .o_issue_id(o_issue_id), .o_issue_payload(o_issue_payload),
    .i_cmpl_valid(i_cmpl_valid), .o_cmpl_ready(o_cmpl_ready), .i_cmpl_ch(i_cmpl_ch),
    .i_cmpl_id(i_cmpl_id), .o_resp_wr(o_resp_wr), .o_resp_desc_id(o_resp_desc_id),
    .o_resp_ch_sel(o_resp_ch_sel), .i_resp_wready(i_resp_wready), .o_cmpl_err(o_cmpl_err)
  );

  function automatic bit exp_desc_ready();
    if (!aenable) return 1'b0;
    return (mq[i_desc_ch_sel].size() < QDEPTH) && !i_abort[i_desc_ch_sel];
  endfunction

  task automatic model_update();
    int pick;
    int c;
    bit rdy;
    int old_out [NUM_CH];
    logic [55:0] item;
    rdy = exp_desc_ready();
    if (!aenable) return;
    pick = -1;
    if (!m_iv || i_issue_ready) begin
      for (int pass = 0; pass < 2; pass++)
        for (int k = 1; k <= NUM_CH; k++) begin
          c = (m_rr + k) % NUM_CH;
          if (pick < 0 && mq[c].size() > 0 && m_out[c] < MAX_OUT && !i_abort[c] &&
              (pass == 1 || prio_v[c])) pick = c;
        end
    end
    for (int i = 0; i < NUM_CH; i++) old_out[i] = m_out[i];
    if (pick >= 0) begin
      item = mq[pick].pop_front();
      m_iv = 1; m_ich = pick; m_iid = item[55:48]; m_ipay = item[47:0];
      m_out[pick]++; m_rr = pick;
    end else if (i_issue_ready) m_iv = 0;
    if (i_cmpl_valid && (!m_rv || i_resp_wready)) begin
      c = int'(i_cmpl_ch);
      if (old_out[c] == 0) m_err = 1; else m_out[c]--;
      m_rv = 1; m_rid = i_cmpl_id; m_rch = c;
    end else if (i_resp_wready) m_rv = 0;
    for (int i = 0; i < NUM_CH; i++) if (i_abort[i]) mq[i].delete();
    if (i_desc_valid && rdy) mq[i_desc_ch_sel].push_back({i_desc_id, i_desc_payload});
  endtask

  task automatic step();
    if (aenable && o_issue_valid && i_issue_ready) begin
      hs_ch.push_back(int'(o_issue_ch)); hs_id.push_back(int'(o_issue_id)); hs_cyc.push_back(cyc);
    end
    model_update();
    @(posedge aclk);
    @(negedge aclk);
    cyc++;
  endtask

  task automatic idle();
    aenable = 1'b1; i_abort = '0; i_prio = '0; prio_v = '0;
    i_desc_valid = 1'b0; i_desc_ch_sel = '0; i_desc_id = 8'd0; i_desc_payload = '0;
    i_issue_ready = 1'b0; i_cmpl_valid = 1'b0; i_cmpl_ch = '0; i_cmpl_id = 8'd0;
    i_resp_wready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    anreset = 1'b0;
    @(posedge aclk); @(negedge aclk);
    for (int i = 0; i < NUM_CH; i++) begin mq[i].delete(); m_out[i] = 0; end
    m_rr = NUM_CH - 1; m_iv = 0; m_rv = 0; m_err = 0; m_ich = 0; m_rch = 0;
    m_iid = 8'd0; m_rid = 8'd0; m_ipay = '0;
    hs_ch.delete(); hs_id.delete(); hs_cyc.delete();
    anreset = 1'b1;
    @(negedge aclk);
  endtask

  task automatic push(input int ch, input logic [7:0] id);
    i_desc_valid = 1'b1; i_desc_ch_sel = CH_W'(ch); i_desc_id = id; i_desc_payload = {6{id}};
    step();
    i_desc_valid = 1'b0;
  endtask

  task automatic cmpl(input int ch, input logic [7:0] id);
    i_cmpl_valid = 1'b1; i_cmpl_ch = CH_W'(ch); i_cmpl_id = id;
    step();
    i_cmpl_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    anreset = 1'b0;
    @(posedge aclk); #1;
    checks++; if (o_issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%0b want=0", o_issue_valid); end
    checks++; if (o_resp_wr !== 1'b0) begin errors++; $display("FAIL reset_resp_wr got=%0b want=0", o_resp_wr); end
    checks++; if (o_cmpl_err !== 1'b0) begin errors++; $display("FAIL reset_cmpl_err got=%0b want=0", o_cmpl_err); end
    checks++; if ({o_issue_id, o_issue_payload} !== 56'd0) begin errors++; $display("FAIL reset_issue_data got=%h want=0", {o_issue_id, o_issue_payload}); end
    checks++; if (o_resp_desc_id !== 8'd0) begin errors++; $display("FAIL reset_resp_id got=%h want=0", o_resp_desc_id); end
    do_reset();
    checks++; if (o_desc_ready !== 1'b1) begin errors++; $display("FAIL idle_desc_ready got=%0b want=1", o_desc_ready); end
    aenable = 1'b0; #1;
    checks++; if (o_desc_ready !== 1'b0) begin errors++; $display("FAIL disabled_desc_ready got=%0b want=0", o_desc_ready); end
    checks++; if (o_cmpl_ready !== 1'b0) begin errors++; $display("FAIL disabled_cmpl_ready got=%0b want=0", o_cmpl_ready); end
    aenable = 1'b1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < NUM_CH; c++) push(c, 8'(10 + c));
    i_issue_ready = 1'b1;
    repeat (6) step();
    checks++; if (hs_ch.size() != 4) begin errors++; $display("FAIL rr_count got=%0d want=4", hs_ch.size()); end
    for (int k = 0; k < 4 && k < hs_ch.size(); k++) begin
      checks++; if (hs_ch[k] != k || hs_id[k] != 10 + k || hs_cyc[k] != hs_cyc[0] + k) begin
        errors++; $display("FAIL rr_order[%0d] got ch=%0d id=%0d cyc=%0d want ch=%0d id=%0d cyc=%0d",
                           k, hs_ch[k], hs_id[k], hs_cyc[k], k, 10 + k, hs_cyc[0] + k);
      end
    end
  endtask

  task automatic test_max_out();
    do_reset();
    i_issue_ready = 1'b1;
    push(1, 8'h20); push(1, 8'h21); push(1, 8'h22);
    repeat (6) step();
    checks++; if (hs_ch.size() != 2) begin errors++; $display("FAIL maxout_limit got=%0d want=2", hs_ch.size()); end
    cmpl(1, 8'h21);
    checks++; if (o_resp_wr !== 1'b1 || o_resp_ch_sel !== 2'd1 || o_resp_desc_id !== 8'h21) begin
      errors++; $display("FAIL maxout_resp got wr=%0b ch=%0d id=%h want wr=1 ch=1 id=21", o_resp_wr, o_resp_ch_sel, o_resp_desc_id);
    end
    step();
    checks++; if (o_resp_wr !== 1'b0) begin errors++; $display("FAIL maxout_resp_clear got=%0b want=0", o_resp_wr); end
    repeat (2) step();
    checks++; if (hs_ch.size() != 3 || hs_id[hs_id.size()-1] != 8'h22) begin
      errors++; $display("FAIL maxout_third got=%0d last_id=%h want=3 last_id=22", hs_ch.size(), hs_id[hs_id.size()-1]);
    end
  endtask

  task automatic test_full_abort();
    do_reset();
    push(0, 8'h40);
    for (int k = 0; k < QDEPTH; k++) push(2, 8'(8'h50 + k));
    i_desc_ch_sel = 2'd2; #1;
    checks++; if (o_desc_ready !== 1'b0) begin errors++; $display("FAIL full_ready_ch2 got=%0b want=0", o_desc_ready); end
    i_desc_ch_sel = 2'd3; #1;
    checks++; if (o_desc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_ch3 got=%0b want=1", o_desc_ready); end
    i_abort = 4'b0100;
    step();
    i_abort = 4'b0000; i_issue_ready = 1'b1; i_desc_ch_sel = 2'd2; #1;
    checks++; if (o_desc_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_ch2 got=%0b want=1", o_desc_ready); end
    repeat (8) step();
    checks++; if (hs_ch.size() != 1 || hs_ch[0] != 0) begin
      errors++; $display("FAIL abort_no_ch2 got=%0d issues want=1 (ch0 only)", hs_ch.size());
    end
  endtask

  task automatic test_hold_abort();
    do_reset();
    push(1, 8'h55);
    step();
    i_abort = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (o_issue_valid !== 1'b1 || o_issue_ch !== 2'd1 || o_issue_id !== 8'h55 || o_issue_payload !== {6{8'h55}}) begin
        errors++; $display("FAIL hold_stable[%0d] got v=%0b ch=%0d id=%h pay=%h want v=1 ch=1 id=55 pay=555555555555",
                           k, o_issue_valid, o_issue_ch, o_issue_id, o_issue_payload);
      end
    end
    i_abort = 4'b0000; i_issue_ready = 1'b1;
    step();
    i_issue_ready = 1'b0;
    checks++; if (hs_ch.size() != 1) begin errors++; $display("FAIL hold_issued got=%0d want=1", hs_ch.size()); end
    cmpl(1, 8'h55);
    checks++; if (o_resp_wr !== 1'b1 || o_cmpl_err !== 1'b0) begin
      errors++; $display("FAIL hold_cmpl got wr=%0b err=%0b want wr=1 err=0", o_resp_wr, o_cmpl_err);
    end
    i_issue_ready = 1'b1;
    push(1, 8'h56); push(1, 8'h57);
    repeat (6) step();
    checks++; if (hs_ch.size() != 3) begin errors++; $display("FAIL hold_credit_back got=%0d want=3", hs_ch.size()); end
  endtask

  task automatic test_cmpl_err();
    do_reset();
    cmpl(3, 8'h77);
    checks++; if (o_cmpl_err !== 1'b1 || o_resp_wr !== 1'b1 || o_resp_ch_sel !== 2'd3 || o_resp_desc_id !== 8'h77) begin
      errors++; $display("FAIL err_set got err=%0b wr=%0b ch=%0d id=%h want err=1 wr=1 ch=3 id=77",
                         o_cmpl_err, o_resp_wr, o_resp_ch_sel, o_resp_desc_id);
    end
    repeat (4) step();
    checks++; if (o_cmpl_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b want=1", o_cmpl_err); end
    push(0, 8'h60);
    i_resp_wready = 1'b0;
    cmpl(0, 8'h61);
    checks++; if (o_issue_valid !== 1'b1 || o_resp_wr !== 1'b1) begin
      errors++; $display("FAIL pre_reset_busy got v=%0b wr=%0b want v=1 wr=1", o_issue_valid, o_resp_wr);
    end
    #2 anreset = 1'b0;
    #1;
    checks++; if ({o_issue_valid, o_resp_wr, o_cmpl_err, o_issue_ch, o_issue_id, o_resp_desc_id, o_resp_ch_sel} !== 24'd0 ||
                  o_issue_payload !== '0) begin
      errors++; $display("FAIL midstream_reset got v=%0b wr=%0b err=%0b id=%h rid=%h want all 0",
                         o_issue_valid, o_resp_wr, o_cmpl_err, o_issue_id, o_resp_desc_id);
    end
    @(negedge aclk);
    do_reset();
  endtask

  task automatic test_random();
    int c;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      aenable        = ($urandom_range(0, 9) != 0);
      i_desc_valid   = 1'($urandom_range(0, 1));
      i_desc_ch_sel  = CH_W'($urandom_range(0, NUM_CH - 1));
      i_desc_id      = 8'($urandom());
      i_desc_payload = PW'({$urandom(), $urandom()});
      for (int i = 0; i < NUM_CH; i++) i_abort[i] = ($urandom_range(0, 31) == 0);
      i_issue_ready  = ($urandom_range(0, 9) < 6);
      i_resp_wready  = ($urandom_range(0, 9) < 6);
      c = $urandom_range(0, NUM_CH - 1);
      i_cmpl_valid   = (m_out[c] > 0) && ($urandom_range(0, 1) == 1);
      i_cmpl_ch      = CH_W'(c);
      i_cmpl_id      = 8'($urandom());
`ifdef DMA_DISP_PRIO_EN
      prio_v = NUM_CH'($urandom()); i_prio = prio_v;
`endif
      #1;
      checks++; if (o_desc_ready !== exp_desc_ready()) begin errors++; $display("FAIL rnd_desc_ready n=%0d got=%0b want=%0b", n, o_desc_ready, exp_desc_ready()); end
      checks++; if (o_cmpl_ready !== (aenable && (!m_rv || i_resp_wready))) begin
        errors++; $display("FAIL rnd_cmpl_ready n=%0d got=%0b want=%0b", n, o_cmpl_ready, aenable && (!m_rv || i_resp_wready));
      end
      step();
      checks++; if (o_issue_valid !== m_iv) begin errors++; $display("FAIL rnd_issue_valid n=%0d got=%0b want=%0b", n, o_issue_valid, m_iv); end
      if (m_iv) begin
        checks++; if (o_issue_ch !== CH_W'(m_ich) || o_issue_id !== m_iid || o_issue_payload !== m_ipay) begin
          errors++; $display("FAIL rnd_issue_data n=%0d got ch=%0d id=%h pay=%h want ch=%0d id=%h pay=%h",
                             n, o_issue_ch, o_issue_id, o_issue_payload, m_ich, m_iid, m_ipay);
        end
      end
      checks++; if (o_resp_wr !== m_rv) begin errors++; $display("FAIL rnd_resp_wr n=%0d got=%0b want=%0b", n, o_resp_wr, m_rv); end
      if (m_rv) begin
        checks++; if (o_resp_ch_sel !== CH_W'(m_rch) || o_resp_desc_id !== m_rid) begin
          errors++; $display("FAIL rnd_resp_data n=%0d got ch=%0d id=%h want ch=%0d id=%h", n, o_resp_ch_sel, o_resp_desc_id, m_rch, m_rid);
        end
      end
      checks++; if (o_cmpl_err !== m_err) begin errors++; $display("FAIL rnd_cmpl_err n=%0d got=%0b want=%0b", n, o_cmpl_err, m_err); end
    end
    idle();
  endtask

`ifdef DMA_DISP_PRIO_EN
  task automatic test_prio();
    int exp_seq [8] = '{2, 2, 3, 0, 1, 3, 0, 1};
    do_reset();
    prio_v = 4'b0100; i_prio = prio_v;
    push(2, 8'h30); push(0, 8'h31); push(0, 8'h32); push(1, 8'h33);
    push(1, 8'h34); push(2, 8'h35); push(3, 8'h36); push(3, 8'h37);
    i_issue_ready = 1'b1;
    repeat (12) step();
    checks++; if (hs_ch.size() != 8) begin errors++; $display("FAIL prio_count got=%0d want=8", hs_ch.size()); end
    for (int k = 0; k < 8 && k < hs_ch.size(); k++) begin
      checks++; if (hs_ch[k] != exp_seq[k]) begin errors++; $display("FAIL prio_order[%0d] got=%0d want=%0d", k, hs_ch[k], exp_seq[k]); end
    end
  endtask
`endif

  initial begin
    idle();
    anreset = 1'b0;
    @(negedge aclk);
    test_reset();
    test_round_robin();
    test_max_out();
    test_full_abort();
    test_hold_abort();
    test_cmpl_err();
`ifdef DMA_DISP_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_desc_dispatch.md
Name: dma_desc_dispatch

Overview:
- Parametrised N-channel descriptor dispatcher in the aclk domain, between the descriptor source and the DMA transfer engine.
- Buffers descriptors in per-channel queues and issues them to the engine in round-robin order.
- Limits outstanding transfers per channel, turns engine completions into response writes, and supports per-channel abort.
- Generalises the fixed 2-channel descriptor/response path to NUM_CH channels with flow control and credit limits.

Parameters:
- NUM_CH, 4, number of stream channels (2..16)
- CH_W, $clog2(NUM_CH), channel-select width
- QDEPTH, 4, per-channel descriptor queue depth (power of 2, >=2)
- MAX_OUT, 2, maximum issued-but-uncompleted descriptors per channel (1..15)
- PAYLOAD_W, 48, opaque descriptor payload width (len/size/burst/sel/addrs/endian/write)

Ports:
- aclk  in  1  clock
- anreset  in  1  asynchronous active-low reset
- aenable  in  1  global enable; low freezes all state
- i_abort  in  NUM_CH  per-channel abort, level
- i_desc_valid  in  1  descriptor offered
- o_desc_ready  out  1  descriptor accepted when valid&ready
- i_desc_ch_sel  in  CH_W  target channel
- i_desc_id  in  8  descriptor id
- i_desc_payload  in  PAYLOAD_W  descriptor body
- o_issue_valid  out  1  descriptor presented to engine
- i_issue_ready  in  1  engine accepts
- o_issue_ch  out  CH_W  issued channel
- o_issue_id  out  8  issued id
- o_issue_payload  out  PAYLOAD_W  issued body
- i_cmpl_valid  in  1  engine completion
- o_cmpl_ready  out  1  completion accepted
- i_cmpl_ch  in  CH_W  completing channel
- i_cmpl_id  in  8  completing id
- o_resp_wr  out  1  response valid
- o_resp_desc_id  out  8  response id
- o_resp_ch_sel  out  CH_W  response channel
- i_resp_wready  in  1  response sink ready
- o_cmpl_err  out  1  sticky: completion on channel with zero outstanding

Behaviour:
- Reset (anreset low, async): all queues empty, outstanding counters 0, RR pointer = NUM_CH-1, o_issue_valid=0, o_resp_wr=0, o_cmpl_err=0, issue/resp data outputs 0. o_desc_ready and o_cmpl_ready are combinational and read 0 while aenable=0.
- aenable=0: no push, pop, issue, completion or response transfer; all registers hold; valid outputs hold their level.
- Accept: o_desc_ready = aenable & !full[i_desc_ch_sel] & !i_abort[i_desc_ch_sel]. Descriptor pushed into queue[ch] on handshake; a descriptor with ch_sel >= NUM_CH is accepted and dropped.
- Eligibility: ch eligible = queue nonempty & outstanding[ch] < MAX_OUT & !i_abort[ch].
- Arbitration: when issue register empty, or it handshakes this cycle, pick the first eligible channel after the RR pointer (wrap NUM_CH-1 -> 0). Pop that queue, load the issue register, set o_issue_valid next cycle, outstanding[ch]++, pointer := ch. Arbitration to o_issue_valid latency is 1 cycle; back-to-back issue is possible every cycle.
- Issue stability: while o_issue_valid & !i_issue_ready, ch/id/payload are held unchanged, including under abort of that channel.
- Completion: o_cmpl_ready = aenable & (!o_resp_wr | i_resp_wready). On handshake: outstanding[i_cmpl_ch]-- and response register loads id/ch, o_resp_wr=1 next cycle. Response held until i_resp_wready.
- Same cycle issue and completion on one channel: counter unchanged.
- Completion with outstanding[ch]==0: counter stays 0, o_cmpl_err set (cleared only by reset), response still emitted.
- Abort[ch] high: queue[ch] flushed in that cycle, no accept or issue for ch; outstanding[ch] is not cleared and completions still drain it.
- Queue wrap: read/write pointers are log2(QDEPTH)+1 bits, full/empty by MSB compare.

Optional Feature:
- DMA_DISP_PRIO_EN defined: adds port i_prio (in, NUM_CH), a per-channel high-priority mask. Eligible channels with i_prio set are arbitrated RR among themselves before any low-priority channel. A single shared RR pointer is used.
- Undefined: port absent, pure round-robin.

Test Plan:
- NUM_CH=4: push one descriptor each to ch0..3 (ids 10..13), i_issue_ready=1 -> issues ch0,1,2,3 on consecutive cycles, ids 10,11,12,13.
- MAX_OUT=2: push 3 to ch1, no completions -> exactly 2 issues. Complete ch1 id 0x21 -> third issue next arbitration, o_resp_wr=1 with ch=1, id=0x21.
- Fill ch2 with QDEPTH=4 descriptors -> o_desc_ready=0 for ch_sel=2, still 1 for ch_sel=3. Abort ch2 for 1 cycle -> queue empty, no ch2 issue.
- Hold i_issue_ready=0 for 5 cycles with abort on the presented channel -> o_issue_* stable; issued on ready=1; outstanding decrements on later completion.
- Completion on ch3 with 0 outstanding -> o_cmpl_err=1 and stays 1. Reset mid-stream -> all outputs 0 in the same cycle as anreset falls.
- DMA_DISP_PRIO_EN, i_prio=4'b0100, all queues loaded -> ch2 issued until its queue is empty, then RR over 0,1,3.
